// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter sharing the source side of a 4-phase req/ack CDC channel.
// Ports: clk, rst (sync, active-high); src_valid/src_data/src_ready per
// requester; req_l/ack_l/data_l to the CDC; grant_id, busy, err status.
// Optional ack watchdog: define CDC_ARB_TIMEOUT_EN (limit TO_CYCLES).
module cdc_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int TO_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          src_valid,
    input  logic [N_REQ*DATA_W-1:0]   src_data,
    output logic [N_REQ-1:0]          src_ready,
    output logic                      req_l,
    input  logic                      ack_l,
    output logic [DATA_W-1:0]         data_l,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      err
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } state_t;

    state_t            state, state_n;
    logic              req_n;
    logic [DATA_W-1:0] data_n;
    logic [IW-1:0]     gid_n;
    logic [IW-1:0]     rr_ptr, ptr_n;

    logic              found;
    logic [IW-1:0]     win;
    logic [DATA_W-1:0] win_data;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;
    logic [CW-1:0] cnt, cnt_n;
    logic          err_q, err_n;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // First pass finds the lowest valid overall (wrap-around candidate);
    // second pass overrides it with the lowest valid at/after rr_ptr.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                win   = IW'(i);
                found = 1'b1;
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (src_valid[i] && (IW'(i) >= rr_ptr)) begin
                win = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win) begin
                win_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_n     = req_l;
        data_n    = data_l;
        gid_n     = grant_id;
        ptr_n     = rr_ptr;
        src_ready = '0;
`ifdef CDC_ARB_TIMEOUT_EN
        cnt_n     = cnt;
        err_n     = err_q;
`endif
        unique case (state)
            IDLE: begin
                // A high ack here means the CDC has not finished the previous
                // handshake; granting now would corrupt the 4-phase sequence.
                if (!rst && !ack_l && found) begin
                    src_ready[win] = 1'b1;
                    data_n         = win_data;
                    gid_n          = win;
                    ptr_n          = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
                    req_n          = 1'b1;
                    state_n        = REQ;
`ifdef CDC_ARB_TIMEOUT_EN
                    cnt_n          = '0;
`endif
                end
            end
            REQ: begin
                if (ack_l) begin
                    req_n   = 1'b0;
                    state_n = REL;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (cnt == CW'(TO_CYCLES - 1)) begin
                    req_n   = 1'b0;
                    state_n = REL;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
`endif
            end
            REL: begin
                if (!ack_l) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_l    <= 1'b0;
            data_l   <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
`ifdef CDC_ARB_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            req_l    <= req_n;
            data_l   <= data_n;
            grant_id <= gid_n;
            rr_ptr   <= ptr_n;
`ifdef CDC_ARB_TIMEOUT_EN
            cnt      <= cnt_n;
            err_q    <= err_n;
`endif
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed self-checking bench for cdc_tx_arbiter (default build, no watchdog).
// Drives requesters and a hand-sequenced CDC ack; checks with immediate asserts.
module tb_cdc_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]  src_ready;
    logic          req_l;
    logic          ack_l;
    logic [DW-1:0] data_l;
    logic [1:0]    grant_id;
    logic          busy;
    logic          err;

    int total = 0;
    int bad   = 0;
    int rdy_cnt = 0;

    cdc_tx_arbiter #(
        .N_REQ(N),
        .DATA_W(DW),
        .TO_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_ready(src_ready),
        .req_l(req_l),
        .ack_l(ack_l),
        .data_l(data_l),
        .grant_id(grant_id),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdy_cnt += $countones(src_ready);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a grant, check it, then run the ack handshake.
    task automatic serve(input string tag, input logic [15:0] exp_d,
                         input logic [1:0] exp_g);
        bit got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (req_l) got = 1;
        end
        chk({tag, "_grant_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_data"}, 32'(data_l), 32'(exp_d));
            chk({tag, "_gid"}, 32'(grant_id), 32'(exp_g));
            ack_l = 1'b1;
            step();
            chk({tag, "_req_fall"}, 32'(req_l), 32'd0);
            chk({tag, "_rel_data"}, 32'(data_l), 32'(exp_d));
            ack_l = 1'b0;
            step();
            chk({tag, "_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_data  = '0;
        ack_l     = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(req_l), 32'd0);
        chk("rst_data", 32'(data_l), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single requester, ack after 3 cycles.
        src_data[0*DW +: DW] = 16'h4444;
        src_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(src_ready), 32'h1);
        step();
        src_valid = '0;
        chk("single_req", 32'(req_l), 32'd1);
        chk("single_data", 32'(data_l), 32'h4444);
        chk("single_gid", 32'(grant_id), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_ready_off", 32'(src_ready), 32'd0);
        step();
        step();
        chk("single_req_wait", 32'(req_l), 32'd1);
        ack_l = 1'b1;
        step();
        chk("single_req_fall", 32'(req_l), 32'd0);
        chk("single_rel_busy", 32'(busy), 32'd1);
        chk("single_rel_data", 32'(data_l), 32'h4444);
        ack_l = 1'b0;
        step();
        chk("single_done", 32'(busy), 32'd0);

        // Round robin with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_data[i*DW +: DW] = 16'(16'h1111 * (i + 1));
        end
        rdy_cnt   = 0;
        src_valid = 4'b1111;
        serve("rr0", 16'h1111, 2'd0);
        serve("rr1", 16'h2222, 2'd1);
        serve("rr2", 16'h3333, 2'd2);
        serve("rr3", 16'h4444, 2'd3);
        serve("rr4", 16'h1111, 2'd0);
        src_valid = '0;
        chk("rr_ready_pulses", 32'(rdy_cnt), 32'd5);

        // Pointer wrap: grants 3, then 0, then 3.
        src_valid = 4'b1000;
        serve("wrap0", 16'h4444, 2'd3);
        src_valid = 4'b1001;
        serve("wrap1", 16'h1111, 2'd0);
        serve("wrap2", 16'h4444, 2'd3);
        src_valid = '0;

        // Ack stuck high in IDLE blocks any grant.
        ack_l     = 1'b1;
        src_valid = 4'b0010;
        #1;
        chk("stuck_ready", 32'(src_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stuck_req", 32'(req_l), 32'd0);
            chk("stuck_busy", 32'(busy), 32'd0);
        end
        ack_l = 1'b0;
        serve("unstuck", 16'h2222, 2'd1);
        src_valid = '0;

        // Reset in the middle of REQ.
        src_valid = 4'b0100;
        step();
        chk("mid_req", 32'(req_l), 32'd1);
        chk("mid_gid", 32'(grant_id), 32'd2);
        src_valid = '0;
        do_reset();
        #1;
        chk("mid_rst_req", 32'(req_l), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(data_l), 32'd0);
        src_valid = 4'b1010;
        serve("post_rst", 16'h2222, 2'd1);
        src_valid = '0;

        // No watchdog in this build: REQ waits forever, err stays 0.
        src_valid = 4'b0001;
        step();
        src_valid = '0;
        for (int k = 0; k < 30; k++) step();
        chk("nowd_req", 32'(req_l), 32'd1);
        chk("nowd_err", 32'(err), 32'd0);
        chk("nowd_busy", 32'(busy), 32'd1);
        do_reset();
        #1;
        chk("final_req", 32'(req_l), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
